// File: rtl/ram_access_ctrl_if.sv
// Host write channel of ram_access_ctrl: valid/ready handshake carrying address and data.
interface ram_access_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/ram_access_ctrl.sv
// Owns the RAM address/data/wren inputs: zero-fills after reset or clear_req,
// serves host writes, and scans words back out with the RAM's read latency absorbed.
module ram_access_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    ram_access_ctrl_if.slave  wr,
    input  logic              clear_req,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);
    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] clr_ptr, clr_nxt;
    logic [ADDR_W-1:0] scan_ptr, scan_nxt;
    logic [TICK_W-1:0] tick_cnt, tick_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              wren_nxt;
    logic              issue;
    logic              flush;
    logic              p1_v, p2_v;
    logic [ADDR_W-1:0] p1_a, p2_a;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_ptr == ADDR_LAST) state_nxt = RUN;
            RUN:     if (clear_req) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy        = (state == CLEAR);
        wr.wr_ready = (state == RUN) && !clear_req;
        flush       = (state == RUN) && clear_req;
        addr_nxt    = ram_address;
        data_nxt    = ram_data;
        wren_nxt    = 1'b0;
        clr_nxt     = clr_ptr;
        scan_nxt    = scan_ptr;
        tick_nxt    = tick_cnt;
        issue       = 1'b0;
        case (state)
            CLEAR: begin
                addr_nxt = clr_ptr;
                data_nxt = '0;
                wren_nxt = 1'b1;
                clr_nxt  = clr_ptr + ADDR_W'(1);
            end
            RUN: begin
                if (clear_req) begin
                    clr_nxt  = '0;
                    scan_nxt = '0;
                    tick_nxt = '0;
                end else if (wr.wr_valid) begin
                    addr_nxt = wr.wr_addr;
                    data_nxt = wr.wr_data;
                    wren_nxt = 1'b1;
                    // a blocked tick parks at its last value so the read goes out next free cycle
                    if (!scan_en)                   tick_nxt = '0;
                    else if (tick_cnt != TICK_LAST) tick_nxt = tick_cnt + TICK_W'(1);
                end else if (scan_en && tick_cnt == TICK_LAST) begin
                    addr_nxt = scan_ptr;
                    scan_nxt = scan_ptr + ADDR_W'(1);
                    tick_nxt = '0;
                    issue    = 1'b1;
                end else begin
                    tick_nxt = scan_en ? tick_cnt + TICK_W'(1) : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            clr_ptr     <= '0;
            scan_ptr    <= '0;
            tick_cnt    <= '0;
        end else begin
            ram_address <= addr_nxt;
            ram_data    <= data_nxt;
            ram_wren    <= wren_nxt;
            clr_ptr     <= clr_nxt;
            scan_ptr    <= scan_nxt;
            tick_cnt    <= tick_nxt;
        end
    end

    // Two stages: RAM latches the address one edge after issue, q is sampled one edge later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p1_v     <= 1'b0;
            p2_v     <= 1'b0;
            p1_a     <= '0;
            p2_a     <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else if (flush) begin
            p1_v     <= 1'b0;
            p2_v     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            p1_v     <= issue;
            if (issue) p1_a <= scan_ptr;
            p2_v     <= p1_v;
            p2_a     <= p1_a;
            rd_valid <= p2_v;
            if (p2_v) begin
                rd_addr <= p2_a;
                rd_data <= ram_q;
            end
        end
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: RAM model plus a transaction-level model (shadow memory,
// timed read queue) compared every cycle, with directed literal checks around it.
module tb_ram_access_ctrl;
    localparam int AW    = 5;
    localparam int DW    = 3;
    localparam int DIV   = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear_req = 1'b0;
    logic          scan_en = 1'b0;
    logic [AW-1:0] ram_address, rd_addr;
    logic [DW-1:0] ram_data, rd_data, ram_q;
    logic          ram_wren, rd_valid, busy;
    logic [DW-1:0] mem [DEPTH];

    ram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) wif ();

    ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SCAN_DIV(DIV)) dut (
        .clock(clock), .reset(reset), .wr(wif), .clear_req(clear_req), .scan_en(scan_en),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    // RAM with registered inputs, old-data read during write
    always @(posedge clock) begin
        ram_q <= mem[ram_address];
        if (ram_wren) mem[ram_address] <= ram_data;
    end

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int addr; int data; int due; } rd_t;
    rd_t rq[$];
    int  shadow [DEPTH];
    bit  m_clr = 1;
    int  m_cidx = 0, m_scan = 0, m_tick = 0, edge_no = 0;
    int  e_addr = 0, e_data = 0, e_wren = 0, e_rdv = 0, e_rda = 0, e_rdd = 0;

    always @(posedge clock or posedge reset) begin
        rd_t r;
        if (reset) begin
            m_clr = 1; m_cidx = 0; m_scan = 0; m_tick = 0; edge_no = 0;
            e_addr = 0; e_data = 0; e_wren = 0; e_rdv = 0; e_rda = 0; e_rdd = 0;
            rq.delete();
            for (int i = 0; i < DEPTH; i++) shadow[i] = 0;
        end else begin
            edge_no++;
            e_rdv = 0;
            if (m_clr) begin
                e_addr = m_cidx; e_data = 0; e_wren = 1;
                m_cidx = (m_cidx == DEPTH - 1) ? 0 : m_cidx + 1;
                if (m_cidx == 0) m_clr = 0;
            end else if (clear_req) begin
                m_clr = 1; m_cidx = 0; m_scan = 0; m_tick = 0; e_wren = 0;
                rq.delete();
                for (int i = 0; i < DEPTH; i++) shadow[i] = 0;
            end else begin
                if (rq.size() > 0 && rq[0].due == edge_no) begin
                    r = rq.pop_front();
                    e_rdv = 1; e_rda = r.addr; e_rdd = r.data;
                end
                if (wif.wr_valid) begin
                    shadow[wif.wr_addr] = wif.wr_data;
                    e_addr = wif.wr_addr; e_data = wif.wr_data; e_wren = 1;
                    m_tick = scan_en ? ((m_tick + 1 > DIV - 1) ? DIV - 1 : m_tick + 1) : 0;
                end else if (scan_en && m_tick == DIV - 1) begin
                    r.addr = m_scan; r.data = shadow[m_scan]; r.due = edge_no + 2;
                    rq.push_back(r);
                    e_addr = m_scan; e_wren = 0;
                    m_scan = (m_scan + 1) % DEPTH;
                    m_tick = 0;
                end else begin
                    e_wren = 0;
                    m_tick = scan_en ? m_tick + 1 : 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("busy",        busy,         m_clr);
            chk("wr_ready",    wif.wr_ready, (!m_clr && !clear_req) ? 1 : 0);
            chk("ram_address", ram_address,  e_addr);
            chk("ram_data",    ram_data,     e_data);
            chk("ram_wren",    ram_wren,     e_wren);
            chk("rd_valid",    rd_valid,     e_rdv);
            chk("rd_addr",     rd_addr,      e_rda);
            chk("rd_data",     rd_data,      e_rdd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic count_busy(input string nm);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy) n++;
            else break;
        end
        chk(nm, n, 32);
    endtask

    task automatic wait_rd(output int a, output int d, output int cyc);
        bit ok = 0;
        a = -1; d = -1; cyc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (rd_valid) begin
                ok = 1; a = rd_addr; d = rd_data; cyc = int'($time / 10);
                break;
            end
        end
        chk("rd_timeout", ok, 1);
    endtask

    initial begin
        int a, d, c, pc, pa, rdv_seen;
        wif.wr_valid = 0; wif.wr_addr = '0; wif.wr_data = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(1, 7));
        step();
        chk_on = 1;
        step();
        @(negedge clock);
        chk("rst_busy", busy, 1);
        chk("rst_ready", wif.wr_ready, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_rdv", rd_valid, 0);
        step();
        reset = 0;
        count_busy("clear_len");
        chk("ready_after_clear", wif.wr_ready, 1);

        step();
        wif.wr_valid = 1; wif.wr_addr = 5'd7; wif.wr_data = 3'd5;
        step();
        wif.wr_valid = 0;
        step();
        scan_en = 1;

        pc = 0; pa = 31;
        for (int k = 0; k < 33; k++) begin
            wait_rd(a, d, c);
            chk("scan_addr", a, (pa + 1) % DEPTH);
            chk("scan_data", d, (a == 7) ? 5 : 0);
            if (k > 0) chk("scan_spacing", c - pc, DIV);
            pa = a; pc = c;
        end

        // burst of three writes covering the next tick
        step(); wif.wr_valid = 1; wif.wr_addr = 5'd1; wif.wr_data = 3'd1;
        step(); wif.wr_addr = 5'd2; wif.wr_data = 3'd2;
        step(); wif.wr_addr = 5'd3; wif.wr_data = 3'd3;
        step(); wif.wr_valid = 0;
        wait_rd(a, d, c);
        chk("defer_addr", a, 1); chk("defer_data", d, 1); chk("defer_spacing", c - pc, 7);
        pc = c;
        wait_rd(a, d, c);
        chk("post_addr2", a, 2); chk("post_data2", d, 2); chk("post_spacing", c - pc, DIV);
        wait_rd(a, d, c);
        chk("post_addr3", a, 3); chk("post_data3", d, 3);

        // clear one cycle after the next read issues
        step(); step();
        clear_req = 1;
        step();
        clear_req = 0;
        rdv_seen = 0;
        begin
            int n = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clock);
                if (rd_valid) rdv_seen++;
                if (busy) n++;
                else break;
            end
            chk("reclear_len", n, 32);
        end
        chk("clear_suppress", rdv_seen, 0);
        wait_rd(a, d, c);
        chk("restart_addr0", a, 0); chk("restart_data0", d, 0);
        wait_rd(a, d, c);
        chk("restart_addr1", a, 1); chk("restart_data1", d, 0);

        // reset in the middle of a clear
        step(); clear_req = 1;
        step(); clear_req = 0;
        repeat (12) step();
        chk("midclear_addr", ram_address, 11);
        reset = 1;
        @(negedge clock);
        chk("midrst_busy", busy, 1);
        chk("midrst_addr", ram_address, 0);
        chk("midrst_wren", ram_wren, 0);
        chk("midrst_ready", wif.wr_ready, 0);
        step();
        reset = 0;
        count_busy("restart_clear_len");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            wif.wr_valid = ($urandom % 4 == 0);
            wif.wr_addr  = AW'($urandom);
            wif.wr_data  = DW'($urandom);
            clear_req    = ($urandom % 300 == 0);
            scan_en      = ($urandom % 16 != 0);
            reset        = ($urandom % 2000 == 0);
        end
        step();
        reset = 0; clear_req = 0; wif.wr_valid = 0;
        repeat (4) step();
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Front-end controller that sits directly upstream of the 32x3 RAM and owns its address, data and wren inputs. After reset and on request, it clears every word to zero. It accepts host write requests over a valid/ready handshake. When idle, it scans the RAM, reading every word in turn and returning each word with its address for display, compensating for the RAM's registered-input latency.

## Interface
- ADDR_W, 5, RAM address width; depth is 2**ADDR_W.
- DATA_W, 3, RAM word width.
- SCAN_DIV, 4, clock cycles between scan reads; must be ≥ 1.

- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_valid  input  1  host write request.
- wr_ready  output  1  controller can accept a write this cycle.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- clear_req  input  1  one-cycle request to re-clear the whole RAM.
- scan_en  input  1  enables background scan reads.
- ram_address  output  ADDR_W  drives the RAM address input; registered.
- ram_data  output  DATA_W  drives the RAM data input; registered.
- ram_wren  output  1  drives the RAM wren input; registered.
- ram_q  input  DATA_W  RAM read data.
- rd_addr  output  ADDR_W  address of the last scanned word.
- rd_data  output  DATA_W  data of the last scanned word.
- rd_valid  output  1  one-cycle pulse when rd_addr/rd_data update.
- busy  output  1  high while clearing.

## Operation
- States:
  - CLEAR: zero-fills the RAM.
  - RUN: serves writes and scans.
- CLEAR:
  - On each edge, ram_address<=clr_ptr, ram_data<=0, ram_wren<=1, clr_ptr<=clr_ptr+1.
  - After the edge that issues address 2**ADDR_W-1, the state moves to RUN and clr_ptr returns to 0.
  - A clear takes exactly 2**ADDR_W cycles.
  - busy=1 and wr_ready=0 throughout. clear_req is ignored in CLEAR.
- RUN: wr_ready=1 and busy=0. Priority, highest first:
  - clear_req: enter CLEAR with clr_ptr=0 and scan_ptr=0. Any in-flight scan read is discarded and its rd_valid pulse suppressed. A write presented in the same cycle is not accepted, because wr_ready falls.
  - Write accepted (wr_valid&wr_ready): ram_address<=wr_addr, ram_data<=wr_data, ram_wren<=1. Back-to-back writes are accepted every cycle.
  - Scan tick (scan_en=1 and tick_cnt==SCAN_DIV-1): ram_address<=scan_ptr, ram_wren<=0, scan_ptr<=scan_ptr+1 with wrap from 2**ADDR_W-1 to 0, tick_cnt<=0. The issued address is queued in a 2-stage read pipeline.
  - Otherwise: ram_wren<=0. ram_address and ram_data hold their values.
- tick_cnt:
  - Increments each RUN cycle while scan_en=1.
  - Saturates at SCAN_DIV-1 while a write blocks the tick, so the read is deferred and not lost.
  - Resets to 0 when scan_en=0.
- scan_ptr persists across scan_en toggles. Only reset and clear zero it.
- Write data is never modified. There is no arithmetic beyond the modulo-2**ADDR_W pointer wrap.

## Timing
- Reset values:
  - ram_address=0, ram_data=0, ram_wren=0.
  - rd_addr=0, rd_data=0, rd_valid=0.
  - busy=1, wr_ready=0.
  - State=CLEAR, clr_ptr=0, scan_ptr=0, tick_cnt=0, read pipeline empty.
- The first clock edge after reset is released issues the clear of address 0.
- Reset asserted mid-clear or mid-scan aborts immediately to the reset values. The clear restarts from address 0.
- The RAM registers its inputs, so q reflects the address issued at edge E only after edge E+1.
- Scan read latency:
  - Issued at edge E.
  - At edge E+2, rd_data<=ram_q and rd_addr<=issued address.
  - rd_valid is high for the single cycle after E+2.
- A write issued at E+1 does not disturb a read issued at E. The read is captured from q before the write reaches the RAM.
- Write latency: accepted at edge E, ram_wren high during cycle E..E+1, written into the RAM at edge E+1.
- With SCAN_DIV=1 and no writes, one read issues every cycle and rd_valid stays high continuously from the third RUN cycle.

## Test plan
- Reset, then release: busy high for 32 cycles, ram_wren=1 with ram_address stepping 0..31 and ram_data=0; then busy=0 and wr_ready=1.
- Write 3'd5 to address 7 with scan_en=0, then set scan_en=1 with SCAN_DIV=4: rd_valid pulses every 4 cycles with rd_addr 0,1,2…; the pulse with rd_addr=7 shows rd_data=5; all other words read 0.
- Hold wr_valid for 3 consecutive cycles (addr 1,2,3; data 1,2,3) during a scan tick: the writes go out back-to-back, the scan read is deferred until the first free cycle, and no scan address is skipped.
- Let the scan run past address 31: rd_addr wraps 31→0 and rd_valid spacing stays at 4 cycles.
- Pulse clear_req one cycle after a scan read issues: that read's rd_valid is suppressed, a 32-cycle clear follows, and the scan restarts at rd_addr=0 with data 0.
- Assert reset midway through a clear (clr_ptr=12): outputs return to their reset values, and the clear restarts at address 0 after reset is released.
